// File: rtl/window_addr_sequencer.sv
// Sweeps every window position across a frame and streams frame/window word address pairs
// over valid/ready, using only incremental adds on registered base addresses.
module window_addr_sequencer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FRAME_ROWS = 64,
    parameter int unsigned FRAME_COLS = 64,
    parameter int unsigned WIN_ROWS   = 4,
    parameter int unsigned WIN_COLS   = 4,
    parameter int unsigned FRAME_BASE = 16,
    parameter int unsigned WIN_BASE   = 16400,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [ADDR_W-1:0] win_addr,
    output logic [15:0]       pos_row,
    output logic [15:0]       pos_col,
    output logic              last_elem,
    output logic              last_pos,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [15:0] LAST_I  = 16'(WIN_ROWS - 1);
    localparam logic [15:0] LAST_J  = 16'(WIN_COLS - 1);
    localparam logic [15:0] LAST_PR = 16'(FRAME_ROWS - WIN_ROWS);
    localparam logic [15:0] LAST_PC = 16'(FRAME_COLS - WIN_COLS);

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(FRAME_COLS * WORD_BYTES);
    localparam logic [ADDR_W-1:0] F_BASE    = ADDR_W'(FRAME_BASE);
    localparam logic [ADDR_W-1:0] W_BASE    = ADDR_W'(WIN_BASE);

    logic [1:0]        state_q, state_d;
    logic [15:0]       row_q, row_d, col_q, col_d;
    logic [15:0]       i_q, i_d, j_q, j_d;
    logic [ADDR_W-1:0] frame_q, frame_d, win_q, win_d;
    // Address of (pos_row, 0), of (pos_row, pos_col) and of (pos_row + i, pos_col).
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] pos_base_q, pos_base_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              clear;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        i_d         = i_q;
        j_d         = j_q;
        frame_d     = frame_q;
        win_d       = win_q;
        row_base_d  = row_base_q;
        pos_base_d  = pos_base_q;
        line_base_d = line_base_q;
        clear       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    row_d       = '0;
                    col_d       = '0;
                    i_d         = '0;
                    j_d         = '0;
                    frame_d     = F_BASE;
                    win_d       = W_BASE;
                    row_base_d  = F_BASE;
                    pos_base_d  = F_BASE;
                    line_base_d = F_BASE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    clear   = 1'b1;
                end else if (out_ready) begin
                    if (j_q != LAST_J) begin
                        j_d     = j_q + 16'd1;
                        frame_d = frame_q + WORD_STEP;
                        win_d   = win_q + WORD_STEP;
                    end else if (i_q != LAST_I) begin
                        j_d         = '0;
                        i_d         = i_q + 16'd1;
                        line_base_d = line_base_q + ROW_STEP;
                        frame_d     = line_base_q + ROW_STEP;
                        win_d       = win_q + WORD_STEP;
                    end else if (col_q != LAST_PC) begin
                        j_d         = '0;
                        i_d         = '0;
                        col_d       = col_q + 16'd1;
                        pos_base_d  = pos_base_q + WORD_STEP;
                        line_base_d = pos_base_q + WORD_STEP;
                        frame_d     = pos_base_q + WORD_STEP;
                        win_d       = W_BASE;
                    end else if (row_q != LAST_PR) begin
                        j_d         = '0;
                        i_d         = '0;
                        col_d       = '0;
                        row_d       = row_q + 16'd1;
                        row_base_d  = row_base_q + ROW_STEP;
                        pos_base_d  = row_base_q + ROW_STEP;
                        line_base_d = row_base_q + ROW_STEP;
                        frame_d     = row_base_q + ROW_STEP;
                        win_d       = W_BASE;
                    end else begin
                        state_d = ST_DONE;
                        clear   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                clear   = 1'b1;
            end
        endcase

        // Counters and addresses idle at zero outside a sweep.
        if (clear) begin
            row_d       = '0;
            col_d       = '0;
            i_d         = '0;
            j_d         = '0;
            frame_d     = '0;
            win_d       = '0;
            row_base_d  = '0;
            pos_base_d  = '0;
            line_base_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            frame_q     <= '0;
            win_q       <= '0;
            row_base_q  <= '0;
            pos_base_q  <= '0;
            line_base_q <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            i_q         <= i_d;
            j_q         <= j_d;
            frame_q     <= frame_d;
            win_q       <= win_d;
            row_base_q  <= row_base_d;
            pos_base_q  <= pos_base_d;
            line_base_q <= line_base_d;
        end
    end

    assign out_valid  = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign frame_addr = frame_q;
    assign win_addr   = win_q;
    assign pos_row    = row_q;
    assign pos_col    = col_q;
    assign last_elem  = (state_q == ST_RUN) && (i_q == LAST_I) && (j_q == LAST_J);
    assign last_pos   = (state_q == ST_RUN) && (row_q == LAST_PR) && (col_q == LAST_PC);

endmodule

// File: tb/tb_window_addr_sequencer.sv
// Bench for window_addr_sequencer: a default-parameter instance and a 5x6 frame / 2x3 window
// instance, each checked every cycle against a beat-index model plus literal spot checks.
module tb_window_addr_sequencer;

    localparam int D_TOTAL = 59536;
    localparam int S_TOTAL = 96;

    typedef struct packed {
        logic [31:0] fa;
        logic [31:0] wa;
        logic [15:0] pr;
        logic [15:0] pc;
        logic        le;
        logic        lp;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        d_start = 0, d_abort = 0, d_ready = 0;
    logic        d_valid, d_le, d_lp, d_busy, d_done;
    logic [31:0] d_fa, d_wa;
    logic [15:0] d_pr, d_pc;

    logic        s_start = 0, s_abort = 0, s_ready = 0;
    logic        s_valid, s_le, s_lp, s_busy, s_done;
    logic [31:0] s_fa, s_wa;
    logic [15:0] s_pr, s_pc;

    int vectors = 0;
    int miscompares = 0;

    // Model state: phase 0 idle, 1 run, 2 done; k is the beat index on display.
    int dm_phase, dm_k, d_xfers;
    int sm_phase, sm_k, s_xfers;

    window_addr_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (d_start),
        .abort      (d_abort),
        .out_ready  (d_ready),
        .out_valid  (d_valid),
        .frame_addr (d_fa),
        .win_addr   (d_wa),
        .pos_row    (d_pr),
        .pos_col    (d_pc),
        .last_elem  (d_le),
        .last_pos   (d_lp),
        .busy       (d_busy),
        .done       (d_done)
    );

    window_addr_sequencer #(
        .FRAME_ROWS (5),
        .FRAME_COLS (6),
        .WIN_ROWS   (2),
        .WIN_COLS   (3),
        .FRAME_BASE (0)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (s_start),
        .abort      (s_abort),
        .out_ready  (s_ready),
        .out_valid  (s_valid),
        .frame_addr (s_fa),
        .win_addr   (s_wa),
        .pos_row    (s_pr),
        .pos_col    (s_pc),
        .last_elem  (s_le),
        .last_pos   (s_lp),
        .busy       (s_busy),
        .done       (s_done)
    );

    initial forever #5 clk = ~clk;

    function automatic beat_t model_beat(input int fr, input int fc, input int wr, input int wc,
                                         input int fb, input int k);
        beat_t b;
        int npc, per, pos, e, pr, pc, i, j;
        npc  = fc - wc + 1;
        per  = wr * wc;
        pos  = k / per;
        e    = k % per;
        pr   = pos / npc;
        pc   = pos % npc;
        i    = e / wc;
        j    = e % wc;
        b.fa = 32'(fb + 4 * ((pr + i) * fc + pc + j));
        b.wa = 32'(16400 + 4 * e);
        b.pr = 16'(pr);
        b.pc = 16'(pc);
        b.le = (e == per - 1);
        b.lp = (pr == fr - wr) && (pc == fc - wc);
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_phase <= 0;
            dm_k     <= 0;
            d_xfers  <= 0;
        end else begin
            if (d_valid && d_ready) d_xfers <= d_xfers + 1;
            case (dm_phase)
                0: if (d_start) begin
                    dm_phase <= 1;
                    dm_k     <= 0;
                    d_xfers  <= 0;
                end
                1: if (d_abort) dm_phase <= 0;
                   else if (d_ready) begin
                       if (dm_k == D_TOTAL - 1) dm_phase <= 2;
                       else dm_k <= dm_k + 1;
                   end
                default: dm_phase <= 0;
            endcase
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sm_phase <= 0;
            sm_k     <= 0;
            s_xfers  <= 0;
        end else begin
            if (s_valid && s_ready) s_xfers <= s_xfers + 1;
            case (sm_phase)
                0: if (s_start) begin
                    sm_phase <= 1;
                    sm_k     <= 0;
                    s_xfers  <= 0;
                end
                1: if (s_abort) sm_phase <= 0;
                   else if (s_ready) begin
                       if (sm_k == S_TOTAL - 1) sm_phase <= 2;
                       else sm_k <= sm_k + 1;
                   end
                default: sm_phase <= 0;
            endcase
        end
    end

    task automatic cmp_dut(input string nm, input int ph, input int k, input int fr, input int fc,
                           input int wr, input int wc, input int fb, input logic ov,
                           input logic bz, input logic dn, input logic le, input logic lp,
                           input logic [31:0] fa, input logic [31:0] wa, input logic [15:0] pr,
                           input logic [15:0] pc);
        beat_t e;
        logic  ok;
        vectors++;
        e  = '0;
        ok = (ov == (ph == 1)) && (bz == (ph == 1)) && (dn == (ph == 2));
        if (ph == 1) begin
            e  = model_beat(fr, fc, wr, wc, fb, k);
            ok = ok && (fa == e.fa) && (wa == e.wa) && (pr == e.pr) && (pc == e.pc)
                 && (le == e.le) && (lp == e.lp);
        end else begin
            ok = ok && !le && !lp;
        end
        if (!ok) begin
            miscompares++;
            $display("FAIL %s beat=%0d phase=%0d: got v=%b busy=%b done=%b fa=%0d wa=%0d pos=(%0d,%0d) le=%b lp=%b; want fa=%0d wa=%0d pos=(%0d,%0d) le=%b lp=%b",
                     nm, k, ph, ov, bz, dn, fa, wa, pr, pc, le, lp, e.fa, e.wa, e.pr, e.pc,
                     e.le, e.lp);
        end
    endtask

    always @(negedge clk) begin
        cmp_dut("stream_default", dm_phase, dm_k, 64, 64, 4, 4, 16, d_valid, d_busy, d_done,
                d_le, d_lp, d_fa, d_wa, d_pr, d_pc);
        cmp_dut("stream_small", sm_phase, sm_k, 5, 6, 2, 3, 0, s_valid, s_busy, s_done,
                s_le, s_lp, s_fa, s_wa, s_pr, s_pc);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic drive_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_d_start();
        drive_cycle();
        d_start = 1;
        drive_cycle();
        d_start = 0;
    endtask

    task automatic pulse_s_start();
        drive_cycle();
        s_start = 1;
        drive_cycle();
        s_start = 0;
    endtask

    // Park at the negedge where the default instance shows beat n.
    task automatic wait_d_beat(input int n, input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            @(negedge clk);
            if (dm_phase == 1 && dm_k == n) break;
        end
        if (c == budget) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_d_beat_%0d: got timeout want beat reached", n);
        end
    endtask

    task automatic wait_s_beat(input int n, input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            @(negedge clk);
            if (sm_phase == 1 && sm_k == n) break;
        end
        if (c == budget) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_s_beat_%0d: got timeout want beat reached", n);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(d_valid), 0);
        chk("reset_frame", d_fa, 0);
        chk("reset_win", d_wa, 0);
        chk("reset_busy_done", 32'({d_busy, d_done, d_le, d_lp}), 0);
        drive_cycle();
        rst_n = 1;

        // First beats and the window boundary.
        d_ready = 1;
        pulse_d_start();
        @(negedge clk);
        chk("first_beat_frame", d_fa, 16);
        chk("first_beat_win", d_wa, 16400);
        chk("first_beat_pos", 32'({d_pr, d_pc}), 0);
        wait_d_beat(15, 40);
        chk("beat16_frame", d_fa, 796);
        chk("beat16_win", d_wa, 16460);
        chk("beat16_last_elem", 32'(d_le), 1);
        wait_d_beat(16, 4);
        chk("beat17_frame", d_fa, 20);
        chk("beat17_pos", 32'({d_pr, d_pc}), 32'h0000_0001);

        // start during RUN must be ignored.
        pulse_d_start();

        wait_d_beat(D_TOTAL - 1, 61000);
        chk("final_pos", 32'({d_pr, d_pc}), {16'd60, 16'd60});
        chk("final_frame", d_fa, 16396);
        chk("final_win", d_wa, 16460);
        chk("final_flags", 32'({d_le, d_lp}), 3);
        @(negedge clk);
        chk("done_pulse", 32'(d_done), 1);
        chk("beat_count", 32'(d_xfers), D_TOTAL);
        @(negedge clk);
        chk("idle_after_done", 32'({d_busy, d_done}), 0);

        // Abort after beat 100.
        pulse_d_start();
        wait_d_beat(100, 200);
        d_abort = 1;
        drive_cycle();
        d_abort = 0;
        @(negedge clk);
        chk("abort_valid_busy", 32'({d_valid, d_busy}), 0);
        chk("abort_no_done", 32'(d_done), 0);
        @(negedge clk);
        chk("abort_no_done_later", 32'(d_done), 0);
        pulse_d_start();
        @(negedge clk);
        chk("restart_frame", d_fa, 16);

        // Random stalls on the default instance, ended by abort.
        for (int c = 0; c < 400; c++) begin
            drive_cycle();
            d_ready = 1'($urandom_range(0, 1));
        end
        d_abort = 1;
        drive_cycle();
        d_abort = 0;
        d_ready = 1;

        // Small instance, no stalls.
        s_ready = 1;
        pulse_s_start();
        wait_s_beat(90, 120);
        chk("small_pos33_frame", s_fa, 84);
        chk("small_pos33_pos", 32'({s_pr, s_pc}), {16'd3, 16'd3});
        wait_s_beat(95, 10);
        chk("small_last_frame", s_fa, 116);
        chk("small_last_flags", 32'({s_le, s_lp}), 3);
        @(negedge clk);
        chk("small_done", 32'(s_done), 1);
        chk("small_count", 32'(s_xfers), S_TOTAL);

        // Small instance with random stalls; the model checks every held cycle.
        pulse_s_start();
        for (int c = 0; c < 1000 && sm_phase != 2; c++) begin
            s_ready = 1'($urandom_range(0, 1));
            drive_cycle();
        end
        @(negedge clk);
        chk("small_stall_done", 32'(s_done), 1);
        chk("small_stall_count", 32'(s_xfers), S_TOTAL);
        s_ready = 1;

        // Asynchronous reset mid-sweep.
        drive_cycle();
        pulse_d_start();
        repeat (50) drive_cycle();
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_valid_busy", 32'({d_valid, d_busy, d_done}), 0);
        chk("async_rst_frame", d_fa, 0);
        chk("async_rst_win", d_wa, 0);
        chk("async_rst_pos", 32'({d_pr, d_pc}), 0);
        drive_cycle();
        rst_n = 1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
